// File: rtl/othello_board_engine.sv
// othello_board_engine: NxN Othello board with a sequential legality scan and flip engine.
// Define OTHELLO_SCORE_EN to add the black_count/white_count disk counters.
module othello_board_engine #(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          side,
    input  logic [CW-1:0] x,
    input  logic [CW-1:0] y,
    input  logic          check_req,
    input  logic          move_req,
    input  logic          clear_req,
    output logic          busy,
    output logic          done,
    output logic          legal,
    output logic [7:0]    dir,
    output logic [CW+2:0] flip_count,
    input  logic [CW-1:0] rd_x,
    input  logic [CW-1:0] rd_y,
    output logic [1:0]    rd_q
`ifdef OTHELLO_SCORE_EN
    ,
    output logic [2*CW:0] black_count,
    output logic [2*CW:0] white_count
`endif
);
    localparam int AW = $clog2(N);
    localparam int PW = CW + 2;
    localparam int H  = N / 2;
    typedef logic signed [PW-1:0] pos_t;
    localparam pos_t P1 = {{(PW-1){1'b0}}, 1'b1};
    localparam pos_t M1 = {PW{1'b1}};
    localparam pos_t Z  = '0;
    localparam pos_t NP = pos_t'(N);
    localparam logic [CW+2:0] K1 = {{(CW+2){1'b0}}, 1'b1};
    typedef enum logic [2:0] {IDLE, TARGET, SCAN, FLIP, FIN} state_t;
    state_t state, next_state;
    logic [1:0] board [N][N];
    logic [CW-1:0] tx, ty;
    logic own_side, is_move, first;
    logic [2:0] d;
    pos_t px, py;
    logic [CW+2:0] k, rem;
    function automatic pos_t dx(input logic [2:0] v);
        return (v >= 3'd1 && v <= 3'd3) ? P1 : (v >= 3'd5) ? M1 : Z;
    endfunction
    function automatic pos_t dy(input logic [2:0] v);
        return (v <= 3'd1 || v == 3'd7) ? M1 : (v >= 3'd3 && v <= 3'd5) ? P1 : Z;
    endfunction
    function automatic logic off(input pos_t cx, input pos_t cy);
        return cx < Z || cy < Z || cx >= NP || cy >= NP;
    endfunction
    function automatic logic [2:0] first_dir(input logic [7:0] v, input int from);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) if (v[i] && i >= from) r = 3'(i);
        return r;
    endfunction
    function automatic logic [1:0] init_cell(input int r, input int c);
        return ((r == H-1 && c == H-1) || (r == H && c == H)) ? 2'b10 :
               ((r == H && c == H-1) || (r == H-1 && c == H)) ? 2'b11 : 2'b00;
    endfunction
    logic [1:0] own, opp, cur, nxt_cell;
    pos_t tpx, tpy, nx, ny;
    logic cur_off, nxt_off, tgt_bad, scan_opp, scan_hit, nxt_opp, wen, do_clear;
    logic [2:0] fd0, fdn;
    logic [7:0] dir_upd;
    logic [AW-1:0] wx, wy;
    assign own      = {1'b1, own_side};
    assign opp      = {1'b1, ~own_side};
    assign tpx      = {2'b00, tx};
    assign tpy      = {2'b00, ty};
    assign nx       = px + dx(d);
    assign ny       = py + dy(d);
    assign cur_off  = off(px, py);
    assign nxt_off  = off(nx, ny);
    assign cur      = cur_off ? 2'b00 : board[py[AW-1:0]][px[AW-1:0]];
    assign nxt_cell = nxt_off ? 2'b00 : board[ny[AW-1:0]][nx[AW-1:0]];
    assign tgt_bad  = off(tpx, tpy) || board[ty[AW-1:0]][tx[AW-1:0]] != 2'b00;
    assign scan_opp = !cur_off && cur == opp;
    assign scan_hit = !cur_off && cur == own && k != K1;
    assign nxt_opp  = !nxt_off && nxt_cell == opp;
    assign fd0      = first_dir(dir, 0);
    assign fdn      = first_dir(dir, int'(d) + 1);
    assign do_clear = state == IDLE && clear_req;
    assign wen      = state == FLIP;
    assign wx       = first ? tx[AW-1:0] : px[AW-1:0];
    assign wy       = first ? ty[AW-1:0] : py[AW-1:0];
    assign rd_q     = ({1'b0, rd_x} < (CW+1)'(N) && {1'b0, rd_y} < (CW+1)'(N)) ?
                      board[rd_y[AW-1:0]][rd_x[AW-1:0]] : 2'b00;
    always_comb begin
        dir_upd = dir;
        dir_upd[d] = scan_hit;
    end
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else state <= next_state;
    end
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = clear_req ? FIN : (move_req || check_req) ? TARGET : IDLE;
            TARGET:  next_state = tgt_bad ? FIN : SCAN;
            SCAN:    next_state = (scan_opp || d != 3'd7) ? SCAN : (is_move && |dir_upd) ? FLIP : FIN;
            FLIP:    next_state = (!first && rem == K1) ? FIN : FLIP;
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end
    always_comb begin
        busy = state != IDLE;
        done = state == FIN;
    end
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tx <= '0; ty <= '0; own_side <= 1'b0; is_move <= 1'b0; first <= 1'b0;
            d <= '0; px <= '0; py <= '0; k <= '0; rem <= '0;
            legal <= 1'b0; dir <= '0; flip_count <= '0;
        end else begin
            case (state)
                IDLE: if (clear_req || move_req || check_req) begin
                    tx <= x; ty <= y; own_side <= side; is_move <= move_req;
                    legal <= 1'b0; dir <= '0; flip_count <= '0;
                end
                TARGET: begin
                    d <= 3'd0; k <= K1;
                    px <= tpx + dx(3'd0); py <= tpy + dy(3'd0);
                end
                SCAN: if (scan_opp) begin
                    k <= k + K1; px <= nx; py <= ny;
                end else begin
                    dir <= dir_upd;
                    if (scan_hit) flip_count <= flip_count + k - K1;
                    if (d == 3'd7) legal <= |dir_upd;
                    d <= d + 3'd1; k <= K1; first <= 1'b1;
                    px <= tpx + dx(d + 3'd1); py <= tpy + dy(d + 3'd1);
                end
                // After the target write, walk each captured ray; a ray ends when the next cell is no longer opponent.
                FLIP: if (first) begin
                    first <= 1'b0; rem <= flip_count; d <= fd0;
                    px <= tpx + dx(fd0); py <= tpy + dy(fd0);
                end else begin
                    rem <= rem - K1;
                    if (nxt_opp) begin
                        px <= nx; py <= ny;
                    end else begin
                        d <= fdn; px <= tpx + dx(fdn); py <= tpy + dy(fdn);
                    end
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) board[r][c] <= init_cell(r, c);
        end else if (do_clear) begin
            for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) board[r][c] <= init_cell(r, c);
        end else if (wen) begin
            board[wy][wx] <= own;
        end
    end
`ifdef OTHELLO_SCORE_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            black_count <= (2*CW+1)'(2);
            white_count <= (2*CW+1)'(2);
        end else if (do_clear) begin
            black_count <= (2*CW+1)'(2);
            white_count <= (2*CW+1)'(2);
        end else if (wen) begin
            black_count <= black_count + {{(2*CW){1'b0}}, !own_side} - {{(2*CW){1'b0}}, own_side && !first};
            white_count <= white_count + {{(2*CW){1'b0}}, own_side} - {{(2*CW){1'b0}}, !own_side && !first};
        end
    end
`endif
endmodule

// File: tb/tb_othello_board_engine.sv
// tb_othello_board_engine: scoreboard bench for othello_board_engine against a reference Othello model.
module tb_othello_board_engine;
    localparam int N = 8;
    localparam int CW = 4;
    logic clock = 1'b0, resetn = 1'b0, side = 1'b0;
    logic check_req = 1'b0, move_req = 1'b0, clear_req = 1'b0;
    logic [CW-1:0] x = '0, y = '0, rd_x = '0, rd_y = '0;
    logic busy, done, legal;
    logic [7:0] dir;
    logic [CW+2:0] flip_count;
    logic [1:0] rd_q;
`ifdef OTHELLO_SCORE_EN
    logic [2*CW:0] black_count, white_count;
`endif
    othello_board_engine #(.N(N), .CW(CW)) dut (
        .clock(clock), .resetn(resetn), .side(side), .x(x), .y(y),
        .check_req(check_req), .move_req(move_req), .clear_req(clear_req),
        .busy(busy), .done(done), .legal(legal), .dir(dir), .flip_count(flip_count),
        .rd_x(rd_x), .rd_y(rd_y), .rd_q(rd_q)
`ifdef OTHELLO_SCORE_EN
        , .black_count(black_count), .white_count(white_count)
`endif
    );
    always #5 clock = ~clock;
    typedef struct {logic lg; logic [7:0] dr; int fc; int lat;} exp_t;
    exp_t sbq[$];
    int mb [8][8];
    int dxs [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    int dys [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};
    int n_cmp = 0, n_bad = 0;
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask
    function automatic int cellm(input int cx, input int cy);
        return (cx < 0 || cy < 0 || cx >= N || cy >= N) ? -1 : mb[cy][cx];
    endfunction
    task automatic model_init();
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) mb[r][c] = 0;
        mb[3][3] = 2; mb[4][4] = 2; mb[3][4] = 3; mb[4][3] = 3;
    endtask
    function automatic exp_t predict(input logic s, input int px, input int py, input logic mv);
        exp_t e;
        int own, opp, cx, cy, r, sc;
        own = s ? 3 : 2;
        opp = s ? 2 : 3;
        e = '{1'b0, 8'h00, 0, 2};
        if (cellm(px, py) != 0) return e;
        sc = 0;
        for (int d = 0; d < 8; d++) begin
            r = 0; cx = px + dxs[d]; cy = py + dys[d];
            while (cellm(cx, cy) == opp) begin r++; cx += dxs[d]; cy += dys[d]; end
            sc += r + 1;
            if (r > 0 && cellm(cx, cy) == own) begin e.dr[d] = 1'b1; e.fc += r; end
        end
        e.lg = |e.dr;
        e.lat = 2 + sc + ((mv && e.lg) ? 1 + e.fc : 0);
        return e;
    endfunction
    task automatic apply_move(input logic s, input int px, input int py);
        exp_t e;
        int own, opp, cx, cy;
        own = s ? 3 : 2;
        opp = s ? 2 : 3;
        e = predict(s, px, py, 1'b1);
        if (!e.lg) return;
        mb[py][px] = own;
        for (int d = 0; d < 8; d++) if (e.dr[d]) begin
            cx = px + dxs[d]; cy = py + dys[d];
            while (cellm(cx, cy) == opp) begin mb[cy][cx] = own; cx += dxs[d]; cy += dys[d]; end
        end
    endtask
    task automatic compare_board(input string tag);
        logic [127:0] got, exp;
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) begin
            rd_x = CW'(c); rd_y = CW'(r);
            #1;
            got[(r*8+c)*2 +: 2] = rd_q;
            exp[(r*8+c)*2 +: 2] = 2'(mb[r][c]);
        end
        check(tag, got, exp);
    endtask
    task automatic compare_counts(input string tag);
`ifdef OTHELLO_SCORE_EN
        int b, w;
        b = 0; w = 0;
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) begin
            b += (mb[r][c] == 2) ? 1 : 0;
            w += (mb[r][c] == 3) ? 1 : 0;
        end
        check({tag, "_black"}, 128'(black_count), 128'(b));
        check({tag, "_white"}, 128'(white_count), 128'(w));
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask
    // kind: 0 = check, 1 = move, 2 = clear; poke issues a check_req while the engine is busy
    task automatic run_op(input int kind, input logic s, input int px, input int py, input logic poke);
        exp_t e, g;
        int cyc;
        e = (kind == 2) ? '{1'b0, 8'h00, 0, 1} : predict(s, px, py, kind == 1);
        sbq.push_back(e);
        @(negedge clock);
        side = s; x = CW'(px); y = CW'(py);
        clear_req = kind == 2; move_req = kind == 1; check_req = kind == 0;
        @(negedge clock);
        clear_req = 1'b0; move_req = 1'b0; check_req = 1'b0;
        x = '0; y = '0; side = ~s;
        cyc = 1;
        while (!done && cyc < 400) begin
            check_req = poke && cyc == 2;
            @(negedge clock);
            cyc++;
        end
        check_req = 1'b0;
        g = sbq.pop_front();
        check("done_seen", 128'(done), 128'(1));
        check("latency", 128'(cyc), 128'(g.lat));
        check("legal", 128'(legal), 128'(g.lg));
        check("dir", 128'(dir), 128'(g.dr));
        check("flip_count", 128'(flip_count), 128'(g.fc));
        if (kind == 1) apply_move(s, px, py);
        if (kind == 2) model_init();
        compare_counts("counts");
        @(negedge clock);
        check("done_pulse", 128'(done), 128'(0));
        check("idle_after", 128'(busy), 128'(0));
        compare_board("board");
    endtask
    task automatic abort_move(input logic s, input int px, input int py);
        exp_t e;
        int cyc;
        e = predict(s, px, py, 1'b1);
        @(negedge clock);
        side = s; x = CW'(px); y = CW'(py); move_req = 1'b1;
        @(negedge clock);
        move_req = 1'b0;
        cyc = 1;
        while (cyc < e.lat - 2) begin @(negedge clock); cyc++; end
        check("abort_busy_before", 128'(busy), 128'(1));
        resetn = 1'b0;
        #1;
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_done", 128'(done), 128'(0));
        check("abort_legal", 128'(legal), 128'(0));
        check("abort_dir", 128'(dir), 128'(0));
        check("abort_flip_count", 128'(flip_count), 128'(0));
        @(negedge clock);
        resetn = 1'b1;
        model_init();
        compare_board("abort_board");
        compare_counts("abort_counts");
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        model_init();
        #12;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_legal", 128'(legal), 128'(0));
        check("rst_dir", 128'(dir), 128'(0));
        check("rst_flip_count", 128'(flip_count), 128'(0));
        compare_counts("rst_counts");
        @(negedge clock);
        resetn = 1'b1;
        compare_board("init_board");
        check("init_busy", 128'(busy), 128'(0));
        rd_x = CW'(8); rd_y = CW'(3); #1;
        check("rd_oor_x", 128'(rd_q), 128'(0));
        rd_x = CW'(3); rd_y = CW'(15); #1;
        check("rd_oor_y", 128'(rd_q), 128'(0));
        run_op(0, 1'b0, 4, 2, 1'b0);
        check("check_dir_down", 128'(dir), 128'(8'h10));
        run_op(1, 1'b1, 3, 3, 1'b0);
        run_op(1, 1'b0, 0, 0, 1'b0);
        run_op(1, 1'b0, 4, 2, 1'b0);
        run_op(1, 1'b1, 3, 2, 1'b0);
        run_op(1, 1'b0, 2, 2, 1'b1);
        check("two_way_dir", 128'(dir), 128'(8'h0C));
        run_op(2, 1'b0, 0, 0, 1'b0);
        run_op(1, 1'b0, 4, 2, 1'b0);
        run_op(1, 1'b1, 3, 2, 1'b0);
        abort_move(1'b0, 2, 2);
        run_op(0, 1'b0, 4, 2, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
